// File: rtl/mips_pkg.sv
// Shared constants for the 4-way 32-bit stream demultiplexer.
package mips_pkg;

  localparam int unsigned DEMUX_CH    = 4;
  localparam int unsigned DEMUX_SEL_W = 2;
  localparam int unsigned DEMUX_WIDTH = 32;

  function automatic logic [DEMUX_CH-1:0] sel_onehot(input logic [DEMUX_SEL_W-1:0] sel);
    logic [DEMUX_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_chan.sv
// One demux output channel: a single registered entry, or with DEMUX_SKID_EN a 2-entry FIFO
// (head drives data_o, skid sits behind it).
module demux_chan
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ready_o
);

`ifdef DEMUX_SKID_EN
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             deq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    deq    = (cnt_q != 2'd0) && rd_ready_i;
    case ({wr_en_i, deq})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = wr_data_i;
        else               skid_d = wr_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Skid word (if any) advances to the head on the same edge.
        if (cnt_q == 2'd2) head_d = skid_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with one entry: the new word takes the head.
        head_d = wr_data_i;
      end
      default: ;
    endcase
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q;
  assign ready_o = (cnt_q != 2'd2);
`else
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en_i) begin
      data_d  = wr_data_i;
      valid_d = 1'b1;
    end else if (valid_q && rd_ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ready_o = !valid_q || rd_ready_i;
`endif

endmodule

// File: rtl/demux_4_32b_stream.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on every side.
// Define DEMUX_SKID_EN for 2-entry channels with in_ready free of out_ready paths.
module demux_4_32b_stream
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEMUX_SEL_W-1:0] in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [DEMUX_CH-1:0]    out_valid,
  input  logic [DEMUX_CH-1:0]    out_ready,
  output logic [WIDTH-1:0]       out_data0,
  output logic [WIDTH-1:0]       out_data1,
  output logic [WIDTH-1:0]       out_data2,
  output logic [WIDTH-1:0]       out_data3
);

  logic [DEMUX_CH-1:0] chan_ready;
  logic [DEMUX_CH-1:0] wr_en;
  logic [WIDTH-1:0]    chan_data [DEMUX_CH];
  logic                accept;

  assign in_ready = chan_ready[in_sel];
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept ? sel_onehot(in_sel) : '0;

  for (genvar k = 0; k < DEMUX_CH; k++) begin : g_chan
    demux_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_en[k]),
      .wr_data_i (in_data),
      .rd_ready_i(out_ready[k]),
      .valid_o   (out_valid[k]),
      .data_o    (chan_data[k]),
      .ready_o   (chan_ready[k])
    );
  end

  assign out_data0 = chan_data[0];
  assign out_data1 = chan_data[1];
  assign out_data2 = chan_data[2];
  assign out_data3 = chan_data[3];

endmodule

// File: tb/tb_demux_4_32b_stream.sv
// Directed self-checking bench for demux_4_32b_stream (both builds).
module tb_demux_4_32b_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;

  int tests = 0;
  int fails = 0;

  demux_4_32b_stream #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;
    #3;
    chk("rst_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_d0", out_data0, 32'h0);
    chk("rst_d3", out_data3, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
    step();
    step();
    rst_n = 1'b1;

    // Single word to ch2
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 32'h0000_00A5;
    step();
    in_valid = 1'b0;
    chk("t1_valid", {28'd0, out_valid}, 32'h4);
    chk("t1_d2", out_data2, 32'hA5);
    step();
    chk("t1_clear", {28'd0, out_valid}, 32'h0);

    // Stream 1..8 round-robin across channels
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i % 4);
      in_data  = 32'(i + 1);
      #1;
      chk("stream_in_ready", {31'd0, in_ready}, 32'h1);
      step();
      oh = 4'b0001 << (i % 4);
      chk("stream_valid", {28'd0, out_valid}, {28'd0, oh});
      chk("stream_data", data_of(i % 4), 32'(i + 1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", {28'd0, out_valid}, 32'h0);
    chk("stream_d0_last", out_data0, 32'h5);
    chk("stream_d3_last", out_data3, 32'h8);

    // Back-pressure on ch1
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 32'h11;
    #1;
    chk("bp_first_ready", {31'd0, in_ready}, 32'h1);
    step();
    chk("bp_v1", {28'd0, out_valid}, 32'h2);
    chk("bp_d1", out_data1, 32'h11);
    in_data = 32'h22;
    #1;
`ifdef DEMUX_SKID_EN
    chk("bp_second_ready", {31'd0, in_ready}, 32'h1);
    step();
    in_data = 32'h33;
    #1;
    chk("bp_third_ready", {31'd0, in_ready}, 32'h0);
`else
    chk("bp_second_ready", {31'd0, in_ready}, 32'h0);
`endif
    // Other channel proceeds while ch1 is stuck
    in_sel  = 2'd0;
    in_data = 32'h44;
    #1;
    chk("ch0_ready", {31'd0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("ch0_valid", {28'd0, out_valid}, 32'h3);
    chk("ch0_d0", out_data0, 32'h44);
    chk("ch0_d1_kept", out_data1, 32'h11);
    step();
    chk("ch0_delivered", {28'd0, out_valid}, 32'h2);
    chk("ch1_still", out_data1, 32'h11);
`ifdef DEMUX_SKID_EN
    out_ready = 4'b1111;
    step();
    chk("rel_v", {28'd0, out_valid}, 32'h2);
    chk("rel_d1", out_data1, 32'h22);
    step();
    chk("rel_clear", {28'd0, out_valid}, 32'h0);
`else
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 32'h22;
    #1;
    chk("rel_ready", {31'd0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("rel_v", {28'd0, out_valid}, 32'h2);
    chk("rel_d1", out_data1, 32'h22);
    step();
    chk("rel_clear", {28'd0, out_valid}, 32'h0);
`endif

    // Replace-in-place: accept and deliver together on ch0
    out_ready = 4'b1110;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 32'h55;
    step();
    chk("rep_hold_v", {28'd0, out_valid}, 32'h1);
    chk("rep_hold_d", out_data0, 32'h55);
    out_ready = 4'b1111;
    in_data   = 32'h66;
    #1;
    chk("rep_ready", {31'd0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("rep_v", {28'd0, out_valid}, 32'h1);
    chk("rep_d", out_data0, 32'h66);
    step();
    chk("rep_clear", {28'd0, out_valid}, 32'h0);

    // Asynchronous reset while ch3 holds a word
    out_ready = 4'b0111;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    in_data   = 32'h77;
    step();
    in_valid = 1'b0;
    chk("ar_pre_v", {28'd0, out_valid}, 32'h8);
    chk("ar_pre_d", out_data3, 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_v", {28'd0, out_valid}, 32'h0);
    chk("ar_d3", out_data3, 32'h0);
    step();
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_post_v", {28'd0, out_valid}, 32'h0);
      chk("ar_post_d3", out_data3, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_4_32b_stream.md
# demux_4_32b_stream

Registered 1-to-4, 32-bit stream demultiplexer with valid/ready handshakes on the input and each output. It is the write-direction counterpart of the 4-way 32-bit select mux: it steers one input word to the output channel chosen by a 2-bit select. It sits between a single producer, such as a write-back or load-return path, and four independent consumers. Each channel holds its own output register, so a stall on one channel never corrupts another.

## Interface
Parameters:
- WIDTH, 32, data width of input and every output channel

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- in_sel  in  2  destination channel, 0..3
- in_data  in  WIDTH  input word
- out_valid  out  4  bit k: channel k holds a word
- out_ready  in  4  bit k: consumer k takes the word this cycle
- out_data0..out_data3  out  WIDTH each  channel data, registered

## Operation
- Accept: in_valid && in_ready at a rising edge. in_data is written into channel in_sel only. The other channels are untouched.
- Deliver: out_valid[k] && out_ready[k] at a rising edge. The head word of channel k is consumed.
- Base mode, one entry per channel:
  - in_ready = !out_valid[in_sel] || out_ready[in_sel]
  - This is combinational through in_sel and out_ready.
- Simultaneous accept and deliver on the same channel: the new word replaces the old. out_valid stays 1 and no bubble is inserted.
- Deliver without accept: out_valid[k] clears next cycle. out_data[k] holds its stale value; consumers must qualify data with out_valid.
- in_sel is sampled only on accept. in_sel and in_data are don't-care when in_valid=0.
- Word order is preserved per channel. There is no ordering relation across channels.
- No word is ever dropped or duplicated.
- out_valid is never lowered without a delivery.
- out_data[k] is stable while out_valid[k] && !out_ready[k].

## Timing
- Latency: an accept at edge N gives out_valid[sel]=1 and the word on out_dataN after edge N.
- Throughput: 1 word per cycle aggregate, including back-to-back words to one channel while its consumer is ready.
- Reset (rst_n low, asynchronous):
  - out_valid = 4'b0000
  - out_data0..3 = 0
  - all occupancy state cleared
- in_ready reads 1 while reset is low, since no channel is full. Accepts are ignored until the first edge after rst_n rises.
- Reset mid-transfer: all held words are discarded. Nothing is delivered after reset.

## Configuration
- DEMUX_SKID_EN defined: each channel becomes a 2-entry FIFO, with a head register driving out_dataK and a skid register behind it.
  - in_ready = !full[in_sel], which depends only on registered state and in_sel, with no path from out_ready.
  - A channel is full at 2 entries.
  - Accept and deliver in the same cycle on a full channel: the accept is refused and the deliver proceeds.
  - On delivery, the skid entry moves to the head in the same edge.
  - Latency stays 1 cycle into an empty channel.
- DEMUX_SKID_EN undefined: base one-entry behaviour as in Operation.
- Port list is identical in both builds.

## Structure
- The shared package/header mips_pkg holds:
  - DEMUX_CH = 4
  - DEMUX_SEL_W = 2
  - the default WIDTH = 32
- One sub-module, demux_chan: the per-channel storage with occupancy logic and the DEMUX_SKID_EN variant. It is instantiated four times.
- The top level decodes in_sel into per-channel write enables and muxes the per-channel ready back to in_ready.

## Test plan
- Reset, then send in_sel=2, data 0x0000_00A5, with out_ready=4'b1111 -> out_valid=4'b0100 one cycle later, out_data2=0xA5, then out_valid clears.
- Stream 0x1..0x8 with in_sel cycling 0,1,2,3, all ready -> each channel receives its two words in order: ch0 gets 0x1,0x5 and ch3 gets 0x4,0x8. in_ready stays 1 throughout.
- Hold out_ready[1]=0 and send 0x11 then 0x22 to ch1:
  - base: in_ready drops after 0x11 and 0x22 waits.
  - skid: both accepted, and a third word 0x33 sees in_ready=0.
  - Releasing ready delivers 0x11, 0x22 in order.
- With ch1 blocked, a word 0x44 sent to ch0 -> accepted in the same cycle and delivered on ch0. ch1 contents are unchanged.
- Base mode, ch0 holding 0x55 with out_ready[0]=1, new accept 0x66 to ch0 in the same cycle -> out_valid[0] stays 1 and out_data0=0x66 next cycle.
- Assert rst_n=0 mid-cycle while ch3 holds 0x77 -> out_valid=0 and out_data3=0 immediately, and 0x77 never appears after reset.
